// File: rtl/negedge_gen_pkg.sv
// Shared state type and width helper for the falling-edge generator.
package negedge_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      GAP
   } gen_state_e;

   function automatic int timer_width(input int low_cycles, input int gap_cycles);
      int longest;
      longest = (low_cycles > gap_cycles) ? low_cycles : gap_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/negedge_generator_timer.sv
// Loadable down-counter; done_o marks the last cycle of a loaded interval.
module cycle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N gives exactly N cycles ending on the cycle where the count reads 1.
   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/negedge_generator.sv
// Turns request pulses into LOW_CYCLES-long low phases separated by at least GAP_CYCLES high.
module negedge_generator
   import negedge_gen_pkg::*;
#(
   parameter int LOW_CYCLES = 4,
   parameter int GAP_CYCLES = 2,
   parameter int PEND_MAX   = 7
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pulse_in,
   output logic                            sig_out,
   output logic                            busy,
   output logic [$clog2(PEND_MAX+1)-1:0]   pend_cnt,
   output logic                            overflow
);

   localparam int CNT_W = $clog2(PEND_MAX + 1);
   localparam int TMR_W = timer_width(LOW_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] PEND_LIMIT = CNT_W'(PEND_MAX);
   localparam logic [TMR_W-1:0] LOW_LOAD   = TMR_W'(LOW_CYCLES);
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES);

   gen_state_e       state_q, state_d;
   logic [CNT_W-1:0] pend_q, pend_d, pend_after;
   logic             sig_q, sig_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic             launch, from_queue, enq;
   logic             tmr_load, tmr_done;
   logic [TMR_W-1:0] tmr_val;

   cycle_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_comb begin
      launch     = ((state_q == IDLE) || (state_q == GAP && tmr_done)) &&
                   ((pend_q != '0) || pulse_in);
      from_queue = launch && (pend_q != '0);
      pend_after = from_queue ? pend_q - CNT_W'(1) : pend_q;
      // A pulse is only absorbed directly when the queue was empty at launch.
      enq        = pulse_in && !(launch && !from_queue);

      pend_d = pend_after;
      ovf_d  = 1'b0;
      if (enq) begin
         if (pend_after < PEND_LIMIT) begin
            pend_d = pend_after + CNT_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end

      state_d = state_q;
      case (state_q)
         IDLE:    if (launch)   state_d = LOW;
         LOW:     if (tmr_done) state_d = GAP;
         GAP:     if (tmr_done) state_d = launch ? LOW : IDLE;
         default: state_d = IDLE;
      endcase

      tmr_load = (state_d != state_q) && (state_d != IDLE);
      tmr_val  = (state_d == LOW) ? LOW_LOAD : GAP_LOAD;
      sig_d    = (state_d != LOW);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sig_q   <= 1'b1;
         busy_q  <= 1'b0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sig_out  = sig_q;
   assign busy     = busy_q;
   assign pend_cnt = pend_q;
   assign overflow = ovf_q;

endmodule

// File: doc/negedge_generator.md
# negedge_generator

Converts single-cycle request pulses into clean falling edges on a level output: per accepted request, `sig_out` drops low for `LOW_CYCLES` cycles, then returns high for at least `GAP_CYCLES` cycles. A downstream falling-edge detector therefore produces exactly one pulse per accepted request. Requests that arrive while a waveform is in progress are counted and replayed back-to-back. Overflow beyond `PEND_MAX` is flagged, not queued.

## Interface
- `LOW_CYCLES`, default 4: low-phase length in cycles; must be ≥ 1.
- `GAP_CYCLES`, default 2: minimum high phase between edges; must be ≥ 1.
- `PEND_MAX`, default 7: maximum queued requests; must be ≥ 1.
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: reset; asynchronous, active-high.
- `pulse_in` input 1: request, one cycle high per request; consecutive high cycles are separate requests.
- `sig_out` output 1: generated level, registered; idle high.
- `busy` output 1: high when state ≠ IDLE, registered.
- `pend_cnt` output `$clog2(PEND_MAX+1)`: queued-request count, registered.
- `overflow` output 1: one-cycle pulse the cycle after a request is dropped.

## Operation
- Three states:
  - IDLE: `sig_out` = 1.
  - LOW: `sig_out` = 0, timer counts `LOW_CYCLES`.
  - GAP: `sig_out` = 1, timer counts `GAP_CYCLES`.
- Launch condition: evaluated in IDLE, and in the last GAP cycle. A launch occurs when `pend_cnt` > 0 or `pulse_in` = 1.
- On launch, go to LOW and consume exactly one request:
  - If `pend_cnt` > 0, consume a queued request and decrement.
  - Otherwise consume `pulse_in` directly.
- Any `pulse_in` not consumed by a launch tries to enqueue:
  - If the post-decrement count is < `PEND_MAX`, increment.
  - Otherwise drop it and pulse `overflow`.
- Simultaneous consume and enqueue leave `pend_cnt` unchanged, with no overflow.
- LOW always goes to GAP after `LOW_CYCLES`.
- GAP goes to LOW (launch) or to IDLE after `GAP_CYCLES`.
- `pulse_in` during LOW or GAP only affects the queue; the running waveform is never shortened or extended.
- Timer: a down-counter of width `$clog2(max(LOW_CYCLES,GAP_CYCLES)+1)`, loaded on each state entry.
- `pend_cnt` saturates at `PEND_MAX` and never wraps.
- On reset: state IDLE, `sig_out` = 1, `busy` = 0, `pend_cnt` = 0, `overflow` = 0, timer = 0.
  - Takes effect asynchronously at any point, including mid-LOW.
  - Queued requests are discarded.
  - `sig_out` rising to 1 on reset is not a falling edge, so no spurious downstream pulse occurs.

## Timing
- Latency from an idle, empty-queue request to the falling edge:
  - `pulse_in` high in cycle N.
  - `sig_out` is low in cycles N+1 … N+`LOW_CYCLES`.
  - `sig_out` is high from N+`LOW_CYCLES`+1.
  - `busy` is high in N+1 … N+`LOW_CYCLES`+`GAP_CYCLES`.
- Back-to-back period with a non-empty queue: `LOW_CYCLES`+`GAP_CYCLES` cycles, falling edge to falling edge.
- `overflow` is asserted in cycle D+1 for a request dropped in cycle D.
- `pend_cnt` reflects cycle-N events in cycle N+1.
- All outputs come directly from flops, with no combinational input-to-output path.

## Structure
- Package `negedge_gen_pkg` holds:
  - the state enum `gen_state_e` {IDLE, LOW, GAP};
  - any shared width helper functions.
- One sub-module is natural: `cycle_timer`, a loadable down-counter with a `done` flag. The same instance serves both LOW and GAP.
- The enqueue/consume logic and the FSM stay in the top module.

## Test plan
Parameters for all scenarios: `LOW_CYCLES` = 4, `GAP_CYCLES` = 2, `PEND_MAX` = 3.
- Single request:
  - Stimulus: `pulse_in` in cycle 10.
  - Expected: `sig_out` low 11–14, high from 15; `busy` high 11–16, low at 17; `pend_cnt` stays 0.
- Burst: pulses in cycles 10, 11, 12.
  - `pend_cnt` reads 1 at cycle 12 and 2 at cycle 13.
  - Low phases: 11–14, 17–20, 23–26.
  - `pend_cnt` reads 1 at cycle 18 and 0 at cycle 24.
- Overflow: pulses in cycles 10–14.
  - `pend_cnt` saturates at 3 at cycle 14.
  - `overflow` is high in cycle 15 only.
  - Exactly 4 falling edges are generated.
- Simultaneous consume/enqueue:
  - Stimulus: with `pend_cnt` = 1, `pulse_in` in the last GAP cycle.
  - Expected: new LOW starts the next cycle; `pend_cnt` stays 1; no overflow.
- Reset mid-operation:
  - Stimulus: `rst` asserted in cycle 12 during LOW with `pend_cnt` = 2.
  - Expected: `sig_out` = 1 and `busy` = 0 immediately; `pend_cnt` = 0.
  - After release, no edge occurs until a new `pulse_in`.
- End-to-end:
  - Stimulus: 50 randomly spaced pulses, constrained to never overflow; `sig_out` drives a downstream falling-edge detector.
  - Expected: detector emits exactly 50 pulses, in request order.
